// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat channel carrying an opaque control field and data field.
// The master drives the beat; the slave returns ready.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 101
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output ctrl,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  ctrl,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: main entry M plus one-entry skid entry S,
// so upstream ready comes straight from a flop. Flush squashes both entries
// into a bubble. A saturating counter tracks cycles the head beat is stalled.
module pipe_stage_reg #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 101,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_stage_reg_if.slave      up,
  pipe_stage_reg_if.master     dn,
  input  logic                 flush,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic              m_v_q,    m_v_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_v_q,    s_v_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  logic in_fire;
  logic out_fire;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign in_fire  = up.valid & ~s_v_q;
  assign out_fire = m_v_q & dn.ready;

  // Ready depends only on the skid flop, never on downstream ready.
  assign up.ready = ~s_v_q;
  assign dn.valid = m_v_q;
  // Masking ctrl keeps a bubble from ever presenting a write enable.
  assign dn.ctrl  = m_v_q ? m_ctrl_q : '0;
  assign dn.data  = m_data_q;
  assign stall_cnt = cnt_q;

  // Next-state for M and S: flush, then M-free refill, then skid capture.
  always_comb begin
    m_v_d    = m_v_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_v_d    = s_v_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    if (flush) begin
      m_v_d    = 1'b0;
      m_ctrl_d = '0;
      m_data_d = '0;
      s_v_d    = 1'b0;
      s_ctrl_d = '0;
      s_data_d = '0;
    end else if (!m_v_q || out_fire) begin
      if (s_v_q) begin
        // in_ready is low here, so no new beat can collide with the drain.
        m_v_d    = 1'b1;
        m_ctrl_d = s_ctrl_q;
        m_data_d = s_data_q;
        s_v_d    = 1'b0;
      end else if (in_fire) begin
        m_v_d    = 1'b1;
        m_ctrl_d = up.ctrl;
        m_data_d = up.data;
      end else begin
        m_v_d    = 1'b0;
        m_ctrl_d = '0;
      end
    end else if (in_fire) begin
      s_v_d    = 1'b1;
      s_ctrl_d = up.ctrl;
      s_data_d = up.data;
    end
  end

  // Back-pressure counter: clear wins over increment; flush has no effect.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (m_v_q && !dn.ready) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // State registers with asynchronous reset to an empty stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v_q    <= 1'b0;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_v_q    <= 1'b0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
      cnt_q    <= '0;
    end else begin
      m_v_q    <= m_v_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      s_v_q    <= s_v_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, skid back-pressure,
// flush variants, counter saturation/clear and asynchronous mid-run reset.
module tb_pipe_stage_reg;
  localparam int CTRL_W = 5;
  localparam int DATA_W = 101;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic cnt_clr = 1'b0;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) up_if ();
  pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dn_if ();

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .up        (up_if),
    .dn        (dn_if),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    up_if.valid = v;
    up_if.ctrl  = c;
    up_if.data  = d;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_ovalid"}, {127'd0, dn_if.valid}, 128'd0);
    chk({tag, "_octrl"},  {123'd0, dn_if.ctrl},  128'd0);
    chk({tag, "_iready"}, {127'd0, up_if.ready}, 128'd1);
  endtask

  initial begin
    offer(1'b0, '0, '0);
    dn_if.ready = 1'b0;

    // Reset asserted between edges; outputs must clear without a clock.
    #3 rst = 1'b1;
    #1;
    chk_empty("rst");
    chk("rst_odata", {27'd0, dn_if.data}, 128'd0);
    chk("rst_cnt", {125'd0, stall_cnt}, 128'd0);
    step();
    rst = 1'b0;

    // Stream four beats with downstream always ready.
    dn_if.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(1'b1, 5'h1F, DATA_W'(i));
      chk($sformatf("strm_iready%0d", i), {127'd0, up_if.ready}, 128'd1);
      step();
      chk($sformatf("strm_ovalid%0d", i), {127'd0, dn_if.valid}, 128'd1);
      chk($sformatf("strm_odata%0d", i), {27'd0, dn_if.data}, 128'(i));
      chk($sformatf("strm_octrl%0d", i), {123'd0, dn_if.ctrl}, 128'h1F);
    end
    offer(1'b0, '0, '0);
    step();
    chk_empty("strm_end");
    chk("strm_cnt", {125'd0, stall_cnt}, 128'd0);

    // Back-pressure: A lands in M, B in the skid, C is held upstream.
    dn_if.ready = 1'b0;
    offer(1'b1, 5'h01, 101'hA);
    step();
    chk("bp_a_data", {27'd0, dn_if.data}, 128'hA);
    chk("bp_a_iready", {127'd0, up_if.ready}, 128'd1);
    chk("bp_a_cnt", {125'd0, stall_cnt}, 128'd0);
    offer(1'b1, 5'h02, 101'hB);
    step();
    chk("bp_b_iready", {127'd0, up_if.ready}, 128'd0);
    chk("bp_b_data", {27'd0, dn_if.data}, 128'hA);
    chk("bp_b_cnt", {125'd0, stall_cnt}, 128'd1);
    offer(1'b1, 5'h03, 101'hC);
    step();
    chk("bp_c_iready", {127'd0, up_if.ready}, 128'd0);
    chk("bp_c_data", {27'd0, dn_if.data}, 128'hA);
    chk("bp_c_cnt", {125'd0, stall_cnt}, 128'd2);
    dn_if.ready = 1'b1;
    step();
    chk("bp_out_b_data", {27'd0, dn_if.data}, 128'hB);
    chk("bp_out_b_ctrl", {123'd0, dn_if.ctrl}, 128'h02);
    chk("bp_out_b_iready", {127'd0, up_if.ready}, 128'd1);
    step();
    chk("bp_out_c_data", {27'd0, dn_if.data}, 128'hC);
    chk("bp_out_c_ctrl", {123'd0, dn_if.ctrl}, 128'h03);
    offer(1'b0, '0, '0);
    step();
    chk_empty("bp_end");
    chk("bp_end_cnt", {125'd0, stall_cnt}, 128'd2);

    // Flush with both entries full and a beat offered.
    dn_if.ready = 1'b0;
    offer(1'b1, 5'h04, 101'hD);
    step();
    offer(1'b1, 5'h05, 101'hE);
    step();
    chk("fl_full_iready", {127'd0, up_if.ready}, 128'd0);
    chk("fl_full_cnt", {125'd0, stall_cnt}, 128'd3);
    dn_if.ready = 1'b1;
    offer(1'b1, 5'h06, 101'hF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    offer(1'b0, '0, '0);
    chk_empty("fl_full");
    chk("fl_full_cnt2", {125'd0, stall_cnt}, 128'd3);
    step();
    chk_empty("fl_full_after");

    // Flush with concurrent out_fire and a dropped in_fire beat.
    offer(1'b1, 5'h07, 101'h11);
    step();
    chk("fl_of_head", {27'd0, dn_if.data}, 128'h11);
    offer(1'b1, 5'h08, 101'h12);
    flush = 1'b1;
    step();
    flush = 1'b0;
    offer(1'b0, '0, '0);
    chk_empty("fl_of");
    step();
    chk_empty("fl_of_after");
    chk("fl_of_cnt", {125'd0, stall_cnt}, 128'd3);

    // Counter clear, then saturation at 7 under a held stall.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("sat_clr", {125'd0, stall_cnt}, 128'd0);
    dn_if.ready = 1'b0;
    offer(1'b1, 5'h09, 101'h20);
    step();
    offer(1'b0, '0, '0);
    chk("sat_start", {125'd0, stall_cnt}, 128'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("sat_cnt%0d", k), {125'd0, stall_cnt}, 128'((k > 7) ? 7 : k));
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("sat_clr_stall", {125'd0, stall_cnt}, 128'd0);
    step();
    chk("sat_resume", {125'd0, stall_cnt}, 128'd1);

    // Async reset between edges while S is full and out_ready toggles.
    offer(1'b1, 5'h0A, 101'h21);
    step();
    offer(1'b0, '0, '0);
    chk("ar_sfull", {127'd0, up_if.ready}, 128'd0);
    dn_if.ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_empty("ar");
    chk("ar_odata", {27'd0, dn_if.data}, 128'd0);
    chk("ar_cnt", {125'd0, stall_cnt}, 128'd0);
    #1 rst = 1'b0;
    step();
    chk_empty("ar_after1");
    dn_if.ready = 1'b0;
    step();
    chk_empty("ar_after2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline stage register for the MIPS pipeline. It is the generalised successor to the fixed EX/MEM latch.
- Carries a control field and a data field with valid/ready handshaking.
- A one-entry skid buffer lets the upstream ready be driven from registers only.
- Synchronous flush inserts a bubble.
- A saturating counter records back-pressure cycles.

Instantiated between any two pipeline stages (ID/EX, EX/MEM, MEM/WB).

Parameters:
CTRL_W, 5, control field width (default packs mem_write, mem_read, mem_to_reg[1:0], reg_write)
DATA_W, 101, data field width (default packs addPC, alu result, store data, dest reg: 32+32+32+5)
CNT_W, 16, width of back-pressure counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  upstream has a beat
in_ready  out  1  stage can accept a beat
in_ctrl  in  CTRL_W  control field of incoming beat
in_data  in  DATA_W  data field of incoming beat
out_valid  out  1  stage holds a valid beat
out_ready  in  1  downstream accepts beat
out_ctrl  out  CTRL_W  control field, forced 0 when out_valid=0
out_data  out  DATA_W  data field of head beat
flush  in  1  synchronous bubble insert (branch/jump squash)
cnt_clr  in  1  synchronous clear of stall_cnt
stall_cnt  out  CNT_W  saturating count of back-pressured cycles

Behaviour:
- One clock: clk. Reset is asynchronous and active-high, on port rst.
- State:
  - main entry M: m_v, m_ctrl, m_data
  - skid entry S: s_v, s_ctrl, s_data
  - counter cnt
- Reset (asynchronous, any time, including mid-transfer): m_v=s_v=0, all ctrl/data regs=0, cnt=0.
  - Outputs during and after reset: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=1.
  - Upstream must not assert in_valid while rst=1; any such beat is discarded.
- in_ready = !s_v. This is a pure function of registers, with no combinational path from out_ready.
- out_valid = m_v. out_ctrl = m_v ? m_ctrl : 0. out_data = m_data. An invalid stage can never assert a write enable downstream.
- Handshake events:
  - in_fire = in_valid & in_ready
  - out_fire = m_v & out_ready
- Next-state, evaluated in priority order each rising edge:
  1. flush=1: m_v=0, s_v=0, m_ctrl=s_ctrl=0, m_data=s_data=0. A concurrent in_fire beat is dropped and a concurrent out_fire completes. Flush dominates all other events.
  2. M free next cycle (m_v=0 or out_fire):
     - if s_v: M<=S, s_v<=0; a concurrent in_fire is impossible because in_ready=0.
     - else if in_fire: M<=input, m_v<=1.
     - else: m_v<=0, and m_ctrl is cleared to 0.
  3. M held (m_v=1, out_ready=0):
     - if in_fire: S<=input, s_v<=1.
     - else S unchanged.
- Ordering: beats leave in acceptance order. No beat is duplicated or lost except by flush.
- Latency and throughput: 1 cycle from in_fire to out_valid when S is empty. Full throughput of 1 beat/cycle with out_ready held high.
- Capacity: 2 beats (M + S). in_ready falls the cycle after S fills and rises the cycle after S drains.
- Counter update each edge:
  - cnt_clr=1: cnt=0. Clear has priority over increment.
  - else if m_v & !out_ready & cnt != all-ones: cnt+=1.
  - Saturates at 2^CNT_W-1 and holds there.
  - Unaffected by flush.
- Width rules: fields are opaque and copied bit-exact. No arithmetic is performed on ctrl or data.

Test Plan:
- Reset and stream: assert rst mid-cycle, release, then 4 consecutive beats (data 1..4, ctrl 5'h1F) with out_ready=1 -> outputs 0 asynchronously on rst; each beat appears exactly 1 cycle after acceptance; in_ready stays 1; stall_cnt=0.
- Back-pressure/skid: beats A,B,C offered while out_ready=0 -> A in M, B in S, in_ready=0 from the next edge, C held upstream; raise out_ready -> outputs A, B, C in order; stall_cnt equals the number of cycles out_valid & !out_ready.
- Flush with full stage: M and S both valid, in_valid=1, flush=1 for one cycle -> next cycle out_valid=0, out_ctrl=0, in_ready=1; the offered beat is not delivered; stall_cnt unchanged.
- Flush with concurrent out_fire: m_v=1, out_ready=1, flush=1 -> current beat consumed once; stage empty afterwards; no duplicate.
- Counter saturation/clear: CNT_W=3, out_ready=0 with valid beat for 10 cycles -> stall_cnt reaches 7 and holds; cnt_clr=1 in the same cycle as a stall -> stall_cnt=0.
- Async reset mid-operation: S full and out_ready toggling, pulse rst between edges -> all outputs 0 immediately; in_ready=1; no residual beat after release.
